// File: rtl/tmds_word_aligner.sv
// Receive-side TMDS word aligner: slides a 10-bit window across two raw ISERDES
// words until control tokens line up, then holds that offset while tokens keep arriving.
module tmds_word_aligner #(
  parameter int TOKEN_COUNT    = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic       i_pdata_clk,
  input  logic       i_rst,
  input  logic [9:0] i_pdata,
  input  logic       i_resync,
  output logic [9:0] o_pdata,
  output logic [3:0] o_offset,
  output logic       o_ctrl_token,
  output logic       o_locked
);

  localparam int TMAX = (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT;
  localparam int TW   = ($clog2(TMAX) < 2) ? 2 : $clog2(TMAX);
  localparam logic [TW-1:0] SEARCH_LAST = TW'(SEARCH_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
  localparam logic [7:0]    RUN_TARGET  = 8'(TOKEN_COUNT);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic is_token(input logic [9:0] w);
    case (w)
      10'h354, 10'h0AB, 10'h154, 10'h2AB: is_token = 1'b1;
      default:                            is_token = 1'b0;
    endcase
  endfunction

  logic [9:0]    r_prev;
  logic [18:0]   w_win;
  logic [9:0]    w_cand;
  logic          w_tok;
  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [7:0]    r_run, w_run_nxt;
  logic [3:0]    r_offset, w_offset_nxt;

  // The top bit of the newest word can never fall inside a 10-bit window at offset <= 9.
  assign w_win = {i_pdata[8:0], r_prev};
  assign w_tok = is_token(w_cand);

  // Barrel window: pick the 10 bits starting at the current offset.
  always_comb begin
    w_cand = w_win[9:0];
    case (r_offset)
      4'd0:    w_cand = w_win[9:0];
      4'd1:    w_cand = w_win[10:1];
      4'd2:    w_cand = w_win[11:2];
      4'd3:    w_cand = w_win[12:3];
      4'd4:    w_cand = w_win[13:4];
      4'd5:    w_cand = w_win[14:5];
      4'd6:    w_cand = w_win[15:6];
      4'd7:    w_cand = w_win[16:7];
      4'd8:    w_cand = w_win[17:8];
      4'd9:    w_cand = w_win[18:9];
      default: w_cand = w_win[9:0];
    endcase
  end

  // Acquisition FSM: next state, dwell timer, token run length and window offset.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_run_nxt    = r_run;
    w_offset_nxt = r_offset;
    if (i_resync) begin
      w_state_nxt = ST_SEARCH;
      w_timer_nxt = '0;
      w_run_nxt   = 8'd0;
    end else begin
      case (r_state)
        ST_SEARCH: begin
          if (w_tok) begin
            w_state_nxt = (RUN_TARGET == 8'd1) ? ST_LOCKED : ST_CONFIRM;
            w_run_nxt   = 8'd1;
            w_timer_nxt = '0;
          end else if (r_timer == SEARCH_LAST) begin
            w_offset_nxt = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
            w_timer_nxt  = '0;
          end else begin
            w_timer_nxt = r_timer + TIMER_ONE;
          end
        end
        ST_CONFIRM: begin
          if (w_tok) begin
            w_run_nxt = r_run + 8'd1;
            if (r_run + 8'd1 == RUN_TARGET) begin
              w_state_nxt = ST_LOCKED;
              w_timer_nxt = '0;
            end else begin
              w_state_nxt = ST_CONFIRM;
            end
          end else begin
            // A broken run means this offset was a false hit; re-hunt without moving.
            w_state_nxt = ST_SEARCH;
            w_timer_nxt = '0;
            w_run_nxt   = 8'd0;
          end
        end
        ST_LOCKED: begin
          if (w_tok) begin
            w_timer_nxt = '0;
          end else if (r_timer == LOCK_LAST) begin
            w_state_nxt = ST_SEARCH;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + TIMER_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_timer_nxt = '0;
          w_run_nxt   = 8'd0;
        end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_pdata_clk) begin
    if (i_rst) begin
      r_prev       <= 10'd0;
      r_state      <= ST_SEARCH;
      r_timer      <= '0;
      r_run        <= 8'd0;
      r_offset     <= 4'd0;
      o_pdata      <= 10'd0;
      o_offset     <= 4'd0;
      o_ctrl_token <= 1'b0;
      o_locked     <= 1'b0;
    end else begin
      r_prev       <= i_pdata;
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_run        <= w_run_nxt;
      r_offset     <= w_offset_nxt;
      o_pdata      <= w_cand;
      o_offset     <= w_offset_nxt;
      o_ctrl_token <= w_tok;
      o_locked     <= (w_state_nxt == ST_LOCKED);
    end
  end

endmodule
